// File: rtl/emulib_axi_latency_pipe_pkg.sv
// Shared definitions for the AXI latency pipe: entry field widths and the
// wrap-safe deadline helpers used by both the read and write paths.
package emulib_axi_latency_pipe_pkg;

  // AXI burst length field width (arlen/awlen).
  localparam int AXI_LEN_W = 8;

  // A programmed latency of zero still costs one cycle.
  function automatic logic [63:0] lat_min1(input logic [63:0] lat);
    return (lat == 64'd0) ? 64'd1 : lat;
  endfunction

  // Deadline reached when (now - dl) mod 2^ts_w has its MSB clear. Callers
  // zero-extend ts_w-bit values, so the low ts_w bits of the 64-bit difference
  // are exactly the modular difference.
  function automatic logic ts_reached(input logic [63:0] now, input logic [63:0] dl,
                                      input int ts_w);
    logic [63:0] diff;
    diff = now - dl;
    return ~diff[ts_w-1];
  endfunction

endpackage

// File: rtl/emulib_axi_latency_pipe_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is always visible
// on rdata_o. Pushes when full and pops when empty are ignored.
module emulib_latency_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
    return (p == LAST) ? '0 : p + IW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = do_push ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // Control state; reset empties the queue regardless of stored data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/emulib_axi_latency_pipe.sv
// AXI timing emulator: accepts AR/AW/W, then returns R beats and B responses
// in acceptance order once a per-burst latency deadline has passed.
module emulib_axi_latency_pipe
  import emulib_axi_latency_pipe_pkg::*;
#(
  parameter int ID_WIDTH       = 4,
  parameter int MAX_R_INFLIGHT = 4,
  parameter int MAX_W_INFLIGHT = 4,
  parameter int LAT_WIDTH      = 16,
  parameter int TS_WIDTH       = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [LAT_WIDTH-1:0]              r_latency,
  input  logic [LAT_WIDTH-1:0]              w_latency,
  input  logic                              arvalid,
  output logic                              arready,
  input  logic [ID_WIDTH-1:0]               arid,
  input  logic [7:0]                        arlen,
  input  logic                              awvalid,
  output logic                              awready,
  input  logic [ID_WIDTH-1:0]               awid,
  input  logic [7:0]                        awlen,
  input  logic                              wvalid,
  output logic                              wready,
  input  logic                              wlast,
  output logic                              rvalid,
  input  logic                              rready,
  output logic [ID_WIDTH-1:0]               rid,
  output logic                              rlast,
  output logic                              bvalid,
  input  logic                              bready,
  output logic [ID_WIDTH-1:0]               bid,
  output logic [$clog2(MAX_R_INFLIGHT):0]   r_inflight,
  output logic [$clog2(MAX_W_INFLIGHT):0]   w_inflight
);
  localparam int WCW  = $clog2(MAX_W_INFLIGHT) + 1;
  localparam int RE_W = ID_WIDTH + AXI_LEN_W + TS_WIDTH;
  localparam int AE_W = ID_WIDTH + AXI_LEN_W;

  // ---------------- free-running timestamp ----------------
  logic [TS_WIDTH-1:0] now_q, now_d;
  assign now_d = now_q + TS_WIDTH'(1);

  // Cycle counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) now_q <= '0;
    else     now_q <= now_d;
  end

  // ---------------- read path ----------------
  logic                 ar_hs, r_hs, r_pop, r_full, r_empty;
  logic [RE_W-1:0]      r_wdata, r_rdata;
  logic [ID_WIDTH-1:0]  r_hd_id;
  logic [7:0]           r_hd_len, r_beat_q, r_beat_d;
  logic [TS_WIDTH-1:0]  r_hd_dl, r_dl_new;

  // arready comes from the registered count only; a burst retiring this
  // cycle frees its slot on the next one.
  assign arready  = ~r_full;
  assign ar_hs    = arvalid & arready;
  assign r_dl_new = now_q + TS_WIDTH'(lat_min1(64'(r_latency)));
  assign r_wdata  = {arid, arlen, r_dl_new};
  assign {r_hd_id, r_hd_len, r_hd_dl} = r_rdata;

  assign rvalid = ~r_empty & ts_reached(64'(now_q), 64'(r_hd_dl), TS_WIDTH);
  assign rlast  = rvalid & (r_beat_q == r_hd_len);
  assign rid    = rvalid ? r_hd_id : '0;
  assign r_hs   = rvalid & rready;
  assign r_pop  = r_hs & rlast;

  emulib_latency_fifo #(.WIDTH(RE_W), .DEPTH(MAX_R_INFLIGHT)) u_rq (
    .clk(clk), .rst(rst), .push_i(ar_hs), .wdata_i(r_wdata), .pop_i(r_pop),
    .rdata_o(r_rdata), .count_o(r_inflight), .full_o(r_full), .empty_o(r_empty)
  );

  // Beat index within the head read burst.
  always_comb begin
    r_beat_d = r_beat_q;
    if (r_hs) r_beat_d = rlast ? 8'd0 : r_beat_q + 8'd1;
  end

  // Beat counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_beat_q <= '0;
    else     r_beat_q <= r_beat_d;
  end

  // ---------------- write path ----------------
  // Address entries and W-completion deadlines sit in two FIFOs. W bursts
  // complete in AW order, so the i-th completion belongs to the i-th AW and
  // the two heads always describe the same (oldest) transaction.
  logic                 aw_hs, wl_hs, b_hs;
  logic                 aw_full, aw_empty, wd_full, wd_empty;
  logic [AE_W-1:0]      aw_rdata;
  logic [ID_WIDTH-1:0]  aw_hd_id;
  logic [7:0]           aw_hd_len;
  logic [WCW-1:0]       aw_count, wd_count;
  logic [TS_WIDTH-1:0]  w_dl_new, wd_hd_dl;
  logic                 unused_w;

  assign awready  = ~aw_full;
  assign aw_hs    = awvalid & awready;
  // Some accepted AW still waits for its wlast.
  assign wready   = (aw_count != wd_count);
  assign wl_hs    = wvalid & wready & wlast;
  assign w_dl_new = now_q + TS_WIDTH'(lat_min1(64'(w_latency)));
  assign {aw_hd_id, aw_hd_len} = aw_rdata;

  assign bvalid     = ~wd_empty & ts_reached(64'(now_q), 64'(wd_hd_dl), TS_WIDTH);
  assign bid        = bvalid ? aw_hd_id : '0;
  assign b_hs       = bvalid & bready;
  assign w_inflight = aw_count;
  // awlen rides along with the entry for debug visibility only; wlast
  // decides completion.
  assign unused_w   = ^{aw_empty, wd_full, aw_hd_len};

  emulib_latency_fifo #(.WIDTH(AE_W), .DEPTH(MAX_W_INFLIGHT)) u_awq (
    .clk(clk), .rst(rst), .push_i(aw_hs), .wdata_i({awid, awlen}), .pop_i(b_hs),
    .rdata_o(aw_rdata), .count_o(aw_count), .full_o(aw_full), .empty_o(aw_empty)
  );

  emulib_latency_fifo #(.WIDTH(TS_WIDTH), .DEPTH(MAX_W_INFLIGHT)) u_wdq (
    .clk(clk), .rst(rst), .push_i(wl_hs), .wdata_i(w_dl_new), .pop_i(b_hs),
    .rdata_o(wd_hd_dl), .count_o(wd_count), .full_o(wd_full), .empty_o(wd_empty)
  );

endmodule

// File: tb/tb_emulib_axi_latency_pipe.sv
// Directed bench for emulib_axi_latency_pipe: a per-cycle vector table for
// the read timing / occupancy cases, plus hand sequences for latency, write,
// timestamp wrap and reset corners.
module tb_emulib_axi_latency_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r_latency = '0, w_latency = '0;
  logic       arvalid = 0, awvalid = 0, wvalid = 0, wlast = 0, rready = 0, bready = 0;
  logic [3:0] arid = '0, awid = '0;
  logic [7:0] arlen = '0, awlen = '0;
  logic       arready, awready, wready, rvalid, rlast, bvalid;
  logic [3:0] rid, bid;
  logic [2:0] r_inflight, w_inflight;

  int errors = 0;
  int checks = 0;
  logic [9:0] tnow;

  emulib_axi_latency_pipe #(
    .ID_WIDTH(4), .MAX_R_INFLIGHT(4), .MAX_W_INFLIGHT(4), .LAT_WIDTH(8), .TS_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .r_latency(r_latency), .w_latency(w_latency),
    .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rlast(rlast),
    .bvalid(bvalid), .bready(bready), .bid(bid),
    .r_inflight(r_inflight), .w_inflight(w_inflight)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cleared by reset, +1 per clock, 10-bit wrap.
  always @(posedge clk or posedge rst) begin
    if (rst) tnow <= '0;
    else     tnow <= tnow + 10'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       arv;
    logic [3:0] aid;
    logic [7:0] alen;
    logic [7:0] lat;
    logic       rrdy;
    logic       e_ardy;
    logic       e_rv;
    logic       e_rl;
    logic [3:0] e_rid;
    logic [2:0] e_inf;
  } vec_t;

  function automatic vec_t mk(input logic arv, input logic [3:0] aid, input logic [7:0] alen,
                              input logic [7:0] lat, input logic rrdy, input logic e_ardy,
                              input logic e_rv, input logic e_rl, input logic [3:0] e_rid,
                              input logic [2:0] e_inf);
    vec_t v;
    v.arv = arv; v.aid = aid; v.alen = alen; v.lat = lat; v.rrdy = rrdy;
    v.e_ardy = e_ardy; v.e_rv = e_rv; v.e_rl = e_rl; v.e_rid = e_rid; v.e_inf = e_inf;
    return v;
  endfunction

  // Issue one AR at the current negedge; return at the next negedge with
  // arvalid dropped.
  task automatic issue_ar(input logic [3:0] id, input logic [7:0] len, input logic [7:0] lat);
    arvalid = 1; arid = id; arlen = len; r_latency = lat;
    @(negedge clk);
    arvalid = 0;
  endtask

  // Cycles (1 = current) until rvalid is seen; 0 if the bound expires.
  task automatic wait_rv(input int bound, output int cyc);
    cyc = 0;
    for (int k = 1; k <= bound; k++) begin
      #1;
      if (rvalid) begin
        cyc = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t tbl [22];
  int   cyc;
  int   stale;

  initial begin
    // Table: cycles 0-9 start with an AR (id5,len3,lat5) at now=10;
    // cycles 10-21 start at now=20 with five AR bursts against a 4-deep queue.
    tbl[0]  = mk(1, 5, 3, 5, 1,  1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) tbl[i] = mk(0, 0, 0, 5, 1,  1, 0, 0, 0, 1);
    for (int i = 5; i <= 7; i++) tbl[i] = mk(0, 0, 0, 5, 1,  1, 1, 0, 5, 1);
    tbl[8]  = mk(0, 0, 0, 5, 1,  1, 1, 1, 5, 1);
    tbl[9]  = mk(0, 0, 0, 5, 1,  1, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 2, 0,  1, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 2, 0,  1, 0, 0, 0, 1);
    tbl[12] = mk(1, 2, 0, 2, 0,  1, 1, 1, 0, 2);
    tbl[13] = mk(1, 3, 0, 2, 0,  1, 1, 1, 0, 3);
    tbl[14] = mk(1, 4, 0, 2, 1,  0, 1, 1, 0, 4);
    tbl[15] = mk(1, 4, 0, 2, 0,  1, 1, 1, 1, 3);
    tbl[16] = mk(0, 0, 0, 2, 1,  0, 1, 1, 1, 4);
    tbl[17] = mk(1, 7, 0, 2, 1,  1, 1, 1, 2, 3);
    tbl[18] = mk(0, 0, 0, 2, 1,  1, 1, 1, 3, 3);
    tbl[19] = mk(0, 0, 0, 2, 1,  1, 1, 1, 4, 2);
    tbl[20] = mk(0, 0, 0, 2, 1,  1, 1, 1, 7, 1);
    tbl[21] = mk(0, 0, 0, 2, 0,  1, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst arready", 32'(arready), 1);
    chk("rst awready", 32'(awready), 1);
    chk("rst wready", 32'(wready), 0);
    chk("rst rvalid", 32'(rvalid), 0);
    chk("rst bvalid", 32'(bvalid), 0);
    chk("rst rlast", 32'(rlast), 0);
    chk("rst rid", 32'(rid), 0);
    chk("rst bid", 32'(bid), 0);
    chk("rst r_inflight", 32'(r_inflight), 0);
    chk("rst w_inflight", 32'(w_inflight), 0);
    @(negedge clk);
    rst = 0;

    for (int g = 0; g < 100 && tnow != 10'd10; g++) @(negedge clk);
    chk("align now=10", 32'(tnow), 10);

    for (int i = 0; i < 22; i++) begin
      arvalid = tbl[i].arv; arid = tbl[i].aid; arlen = tbl[i].alen;
      r_latency = tbl[i].lat; rready = tbl[i].rrdy;
      #1;
      chk($sformatf("v%0d arready", i), 32'(arready), 32'(tbl[i].e_ardy));
      chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d rlast", i), 32'(rlast), 32'(tbl[i].e_rl));
      chk($sformatf("v%0d r_inflight", i), 32'(r_inflight), 32'(tbl[i].e_inf));
      if (tbl[i].e_rv) chk($sformatf("v%0d rid", i), 32'(rid), 32'(tbl[i].e_rid));
      @(negedge clk);
    end
    arvalid = 0; rready = 1;

    // Zero latency still takes exactly one cycle.
    issue_ar(4'd3, 8'd0, 8'd0);
    wait_rv(20, cyc);
    chk("lat0 cycles", 32'(cyc), 1);
    chk("lat0 rid", 32'(rid), 3);
    chk("lat0 rlast", 32'(rlast), 1);
    @(negedge clk);

    // Latency 10 then 2 on the following AR: the older entry keeps its 10.
    // Wait starts two cycles after the first AR, so first rvalid is cycle 9.
    arvalid = 1; arid = 4'd1; arlen = 8'd0; r_latency = 8'd10;
    @(negedge clk);
    arid = 4'd2; r_latency = 8'd2;
    @(negedge clk);
    arvalid = 0;
    wait_rv(30, cyc);
    chk("lat10 cycles", 32'(cyc), 9);
    chk("lat10 rid", 32'(rid), 1);
    @(negedge clk);
    #1;
    chk("lat2 rvalid", 32'(rvalid), 1);
    chk("lat2 rid", 32'(rid), 2);
    @(negedge clk);
    #1;
    chk("lat drained", 32'(r_inflight), 0);
    @(negedge clk);

    // Write: AW, two W beats, wlast; B after 3 cycles, stable under bready=0.
    w_latency = 8'd3;
    #1;
    chk("w no-AW wready", 32'(wready), 0);
    awvalid = 1; awid = 4'd9; awlen = 8'd1;
    #1;
    chk("aw awready", 32'(awready), 1);
    @(negedge clk);
    awvalid = 0; wvalid = 1; wlast = 0;
    #1;
    chk("w beat0 wready", 32'(wready), 1);
    chk("w w_inflight", 32'(w_inflight), 1);
    @(negedge clk);
    wlast = 1;
    #1;
    chk("w wlast wready", 32'(wready), 1);
    @(negedge clk);
    wvalid = 0; wlast = 0;
    #1;
    chk("w done wready", 32'(wready), 0);
    chk("b +1 bvalid", 32'(bvalid), 0);
    @(negedge clk);
    #1;
    chk("b +2 bvalid", 32'(bvalid), 0);
    @(negedge clk);
    #1;
    chk("b +3 bvalid", 32'(bvalid), 1);
    chk("b +3 bid", 32'(bid), 9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("b hold%0d bvalid", k), 32'(bvalid), 1);
      chk($sformatf("b hold%0d bid", k), 32'(bid), 9);
    end
    bready = 1;
    @(negedge clk);
    bready = 0;
    #1;
    chk("b popped bvalid", 32'(bvalid), 0);
    chk("b popped w_inflight", 32'(w_inflight), 0);

    // Timestamp wrap: AR at now=1022 with latency 4.
    for (int g = 0; g < 1100 && tnow != 10'd1022; g++) @(negedge clk);
    chk("align now=1022", 32'(tnow), 1022);
    issue_ar(4'd6, 8'd0, 8'd4);
    wait_rv(20, cyc);
    chk("wrap cycles", 32'(cyc), 4);
    chk("wrap rid", 32'(rid), 6);
    @(negedge clk);

    // Reset in the middle of an 8-beat burst drops it for good.
    issue_ar(4'd8, 8'd7, 8'd1);
    wait_rv(20, cyc);
    chk("rst-burst start", 32'(cyc), 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("mid-rst rvalid", 32'(rvalid), 0);
    chk("mid-rst rlast", 32'(rlast), 0);
    chk("mid-rst r_inflight", 32'(r_inflight), 0);
    chk("mid-rst arready", 32'(arready), 1);
    @(negedge clk);
    rst = 0;
    stale = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (rvalid) stale++;
      @(negedge clk);
    end
    chk("post-rst stale beats", 32'(stale), 0);
    chk("post-rst r_inflight", 32'(r_inflight), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/emulib_axi_latency_pipe.md
EMULIB_AXI_LATENCY_PIPE -- requirements
Module: emulib_axi_latency_pipe

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: AXI ID width.
REQ-002 SHALL have parameter MAX_R_INFLIGHT, default 4: read bursts tracked (power of 2, >=1).
REQ-003 SHALL have parameter MAX_W_INFLIGHT, default 4: write bursts tracked (power of 2, >=1).
REQ-004 SHALL have parameter LAT_WIDTH, default 16: latency field width.
REQ-005 SHALL have parameter TS_WIDTH, default 32: cycle timestamp width, > LAT_WIDTH.
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  reset (one clock; reset is asynchronous and active-high).
REQ-007 SHALL have ports: r_latency  in  LAT_WIDTH  read latency cycles; w_latency  in  LAT_WIDTH  write latency cycles.
REQ-008 SHALL have ports: arvalid in 1; arready out 1; arid in ID_WIDTH; arlen in 8: AR handshake and burst length.
REQ-009 SHALL have ports: awvalid in 1; awready out 1; awid in ID_WIDTH; awlen in 8: AW handshake and burst length.
REQ-010 SHALL have ports: wvalid in 1; wready out 1; wlast in 1: W beat handshake.
REQ-011 SHALL have ports: rvalid out 1; rready in 1; rid out ID_WIDTH; rlast out 1: R timing.
REQ-012 SHALL have ports: bvalid out 1; bready in 1; bid out ID_WIDTH: B timing.
REQ-013 SHALL have ports: r_inflight out clog2(MAX_R_INFLIGHT)+1; w_inflight out clog2(MAX_W_INFLIGHT)+1: occupancy.

Function
REQ-014 SHALL run a free-running TS_WIDTH cycle counter `now`, wrapping modulo 2^TS_WIDTH.
REQ-015 SHALL assert arready iff r_inflight < MAX_R_INFLIGHT, registered-count based, no same-cycle bypass from a retiring burst.
REQ-016 SHALL, on AR handshake, push {arid, arlen, deadline = now + max(r_latency,1)} into the read queue; r_latency sampled only at handshake.
REQ-017 SHALL assert rvalid when queue non-empty and (now - head.deadline) mod 2^TS_WIDTH has MSB clear (deadline reached, wrap-safe).
REQ-018 SHALL drive rid = head.id; hold rvalid/rid/rlast stable until rready; emit arlen+1 beats back-to-back while rready=1; rlast on final beat.
REQ-019 SHALL pop the read queue and decrement r_inflight on rlast handshake; simultaneous AR accept and rlast pop leaves r_inflight unchanged.
REQ-020 SHALL assert awready iff w_inflight < MAX_W_INFLIGHT; AW handshake pushes {awid, awlen} and increments w_inflight.
REQ-021 SHALL assert wready iff at least one accepted AW has an incomplete W burst (W-before-AW is not accepted).
REQ-022 SHALL count W beats per oldest incomplete AW; on wvalid&&wready&&wlast mark that entry complete and set its deadline = now + max(w_latency,1).
REQ-023 SHALL ignore awlen for W completion (wlast is authoritative); awlen beat-count mismatch is a bench-flagged error only.
REQ-024 SHALL assert bvalid when oldest entry is W-complete and deadline reached (REQ-017 rule); bid = its id; pop and decrement w_inflight on bready.
REQ-025 SHALL serve R and B strictly in acceptance order per channel; no ID reordering.
REQ-026 SHALL keep latency change mid-flight from affecting already-accepted entries.

Reset
REQ-027 SHALL on rst clear now, both queues, beat counters; arready=awready=1, wready=0, rvalid=bvalid=0, rlast=0, rid=bid=0, r_inflight=w_inflight=0.
REQ-028 SHALL drop all in-flight transactions on rst mid-burst; no R/B issued for them after reset release.

Structure
REQ-029 SHALL place deadline-compare function and entry field widths in a shared include (emulib_latency_defs.vh).
REQ-030 SHALL use one sub-module emulib_latency_fifo (parametric width/depth, async reset, count output) instantiated for R and W queues.

Verification
REQ-031 SHALL test: r_latency=5, AR len=3 at cycle 10, rready=1 -> rvalid cycles 15..18, rlast at 18, rid=arid.
REQ-032 SHALL test: MAX_R_INFLIGHT=4, 5 ARs back-to-back, rready=0 -> arready low after 4th; after one rlast pop, 5th accepted next cycle.
REQ-033 SHALL test: w_latency=3, AW then 2 W beats, wlast at cycle 20 -> bvalid at 23; bready=0 holds bvalid/bid stable.
REQ-034 SHALL test: r_latency=0 -> first rvalid exactly 1 cycle after AR; latency changed 10->2 mid-flight keeps older entry at 10.
REQ-035 SHALL test: now preset near 2^TS_WIDTH-2, r_latency=4 -> rvalid after exactly 4 cycles across wrap.
REQ-036 SHALL test: rst asserted mid read burst -> rvalid=0 immediately, r_inflight=0, no stale beats after release.
